// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;
  // Wide enough to count WIDTH tests plus one VERIFY cycle.
  localparam int STEP_W    = $clog2(SAR_WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    VERIFY = 2'd2
  } state_e;

endpackage

// File: rtl/digi_cmp.sv
// Combinational magnitude comparator: l_g = (a < b), e = (a == b).
module digi_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             l_g,
  output logic             e
);

  assign l_g = (a < b);
  assign e   = (a == b);

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search initiator: drives trial operands onto a
// comparator and binary-searches the hidden target MSB first.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              l_g,
  input  logic              e,
  output logic [WIDTH-1:0]  trial,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              found,
  output logic [STEP_W-1:0] steps
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   trial_q, trial_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               found_q, found_d;
  logic               done_q, done_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    result_d = result_q;
    found_d  = found_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          trial_d = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d   = IDX_W'(WIDTH - 1);
          steps_d = '0;
          state_d = TEST;
        end
      end

      TEST: begin
        steps_d = steps_q + STEP_W'(1);
        if (e) begin
          // Exact hit ends the search early; l_g is meaningless here.
          result_d = trial_q;
          found_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          if (!l_g) trial_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            trial_d[idx_q - IDX_W'(1)] = 1'b1;
            idx_d                      = idx_q - IDX_W'(1);
          end else begin
            state_d = VERIFY;
          end
        end
      end

      VERIFY: begin
        steps_d  = steps_q + STEP_W'(1);
        result_d = trial_q;
        found_d  = e;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      result_q <= result_d;
      found_q  <= found_d;
      done_q   <= done_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Closed-loop bench: sar_search_ctrl drives digi_cmp against a bench-chosen target.
module tb_sar_search_ctrl;
  import sar_pkg::*;

  localparam int W = SAR_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [W-1:0]      target = '0;
  logic              stuck = 1'b0;
  logic              l_g_c, e_c, l_g, e;
  logic [W-1:0]      trial, result;
  logic              busy, done, found;
  logic [STEP_W-1:0] steps;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  int exp_q[$];
  int exp_res;
  bit exp_found;

  always #5 clk = ~clk;

  digi_cmp #(.WIDTH(W)) u_cmp (
    .a   (trial),
    .b   (target),
    .l_g (l_g_c),
    .e   (e_c)
  );

  // A stuck comparator always claims trial < target and never reports equality.
  assign l_g = stuck ? 1'b1 : l_g_c;
  assign e   = stuck ? 1'b0 : e_c;

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .l_g    (l_g),
    .e      (e),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .steps  (steps)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the i-th comparison tries the bits decided so far plus 2**bit;
  // a "yes" (trial below target, or stuck) keeps that bit. An exact hit stops.
  task automatic build_model(input int tgt, input bit stk);
    int acc = 0;
    int t;
    exp_q.delete();
    for (int b = W - 1; b >= 0; b--) begin
      t = acc + (1 << b);
      exp_q.push_back(t);
      if (!stk && t == tgt) begin
        exp_res   = t;
        exp_found = 1'b1;
        return;
      end
      if (stk || t < tgt) acc = t;
    end
    exp_q.push_back(acc);
    exp_res   = acc;
    exp_found = !stk && (acc == tgt);
  endtask

  task automatic run_search(input int tgt, input bit stk, input bit poke, input bit chain);
    int n;
    int d0;
    bit seen;
    target = W'(tgt);
    stuck  = stk;
    build_model(tgt, stk);
    n  = exp_q.size();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_trial", 32'(trial), 32'(exp_q[0]));
    check("busy_first", 32'(busy), 32'd1);
    check("steps_cleared", 32'(steps), 32'd0);
    for (int i = 1; i < n; i++) begin
      if (poke && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("trial_%0d", i), 32'(trial), 32'(exp_q[i]));
      check("busy_mid", 32'(busy), 32'd1);
      check("done_mid", 32'(done), 32'd0);
    end
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(exp_res));
    check("found", 32'(found), 32'(exp_found));
    check("steps", 32'(steps), 32'(n));
    check("trial_held", 32'(trial), 32'(exp_q[n-1]));
    check("done_count", 32'(done_cnt), 32'(d0 + 1));
    if (chain) begin
      // start raised during the done cycle is taken on the following edge
      start = 1'b1;
      tick();
      start = 1'b0;
      check("chain_busy", 32'(busy), 32'd1);
      check("chain_trial", 32'(trial), 32'(1 << (W - 1)));
      check("chain_steps", 32'(steps), 32'd0);
      check("chain_done_low", 32'(done), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 2 * W + 2 && !seen; k++) begin
        tick();
        if (done === 1'b1) seen = 1'b1;
      end
      check("chain_done_seen", 32'(seen), 32'd1);
      check("chain_result", 32'(result), 32'(exp_res));
      tick();
    end else begin
      tick();
      check("done_single", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(exp_res));
      check("steps_held", 32'(steps), 32'(n));
      check("done_count_after", 32'(done_cnt), 32'(d0 + 1));
    end
  endtask

  initial begin
    int d0;
    // Reset state
    tick();
    check("rst_trial", 32'(trial), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // T1..T4 directed, T3 also chains a start on its done cycle
    run_search(10, 1'b0, 1'b0, 1'b0);
    run_search(0, 1'b0, 1'b0, 1'b0);
    run_search(15, 1'b0, 1'b0, 1'b1);
    run_search(7, 1'b0, 1'b1, 1'b0);

    // T5 reset during the second TEST cycle
    target = W'(10);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_trial", 32'(trial), 32'd12);
    rst_n = 1'b0;
    #1;
    check("mid_rst_trial", 32'(trial), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_found", 32'(found), 32'd0);
    check("mid_rst_steps", 32'(steps), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(done_cnt), 32'(d0));
    run_search(5, 1'b0, 1'b0, 1'b0);

    // T6 stuck comparator
    run_search(3, 1'b1, 1'b0, 1'b0);
    stuck = 1'b0;

    // Randomized targets, occasionally poking start while busy
    for (int r = 0; r < 12; r++) begin
      run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
